// File: rtl/cache_2way_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_2way_ctrl
// Purpose  : 2-way set-associative, write-back, write-allocate cache
//            controller with internal tag/valid/dirty/LRU/data arrays.
//            Sits between the processor memory stage and banked main memory.
// Ports    : clk, rst (async, active-low)
//            CPU side : addr, data_in, rd, wr -> data_out, done, cache_hit,
//                       stall, err
//            Mem side : mem_addr, mem_wdata, mem_rd, mem_wr <- mem_rdata,
//                       mem_stall
// Revision : 1.0 - initial release
// ============================================================================
module cache_2way_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int INDEX_W    = 7,
  parameter int WORDS_LOG2 = 2,
  parameter int MEM_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              cache_hit,
  output logic              stall,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall
);

  localparam int OFF_W = WORDS_LOG2 + 1;
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << WORDS_LOG2;

  localparam logic [WORDS_LOG2:0]   ISSUE_ONE = 1;
  localparam logic [WORDS_LOG2-1:0] RET_ONE   = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMPARE  = 3'd1,
    EVICT    = 3'd2,
    FILL     = 3'd3,
    COMPLETE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_idx;
  logic [WORDS_LOG2-1:0] req_word;
  logic [DATA_W-1:0]     req_data;
  logic                  req_wr;
  logic                  err_q;
  logic                  victim;

  // Issue counter carries one extra bit so FILL can tell "all issued"
  logic [WORDS_LOG2:0]   issue_cnt;
  logic [WORDS_LOG2-1:0] issue_word;
  logic [WORDS_LOG2-1:0] ret_cnt;

  // Memory read return pipeline
  logic [MEM_LAT-1:0]    pipe_vld;
  logic [WORDS_LOG2-1:0] pipe_word [MEM_LAT];

  // Storage arrays
  logic [TAG_W-1:0]  tag_arr  [2][SETS];
  logic [DATA_W-1:0] data_arr [2][SETS*WORDS];
  logic [SETS-1:0]   valid    [2];
  logic [SETS-1:0]   dirty    [2];
  logic [SETS-1:0]   lru;

  logic hit0, hit1, hit, hit_way, victim_sel, access_way;
  logic do_access, issue_accept, capture, fill_last;
  logic [DATA_W-1:0] rd_word;
  logic unused_addr0;

  assign unused_addr0 = addr[0];
  assign issue_word   = issue_cnt[WORDS_LOG2-1:0];

  assign hit0    = valid[0][req_idx] && (tag_arr[0][req_idx] == req_tag);
  assign hit1    = valid[1][req_idx] && (tag_arr[1][req_idx] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit0 ? 1'b0 : 1'b1;

  // Fill an empty way first; only fall back to LRU when both are valid
  assign victim_sel = !valid[0][req_idx] ? 1'b0 :
                      !valid[1][req_idx] ? 1'b1 : lru[req_idx];

  // COMPLETE accesses the freshly filled way, COMPARE the matching way
  assign access_way = (state == COMPLETE) ? victim : hit_way;
  assign rd_word    = data_arr[access_way][{req_idx, req_word}];
  assign do_access  = ((state == COMPARE) && hit) || (state == COMPLETE);

  assign issue_accept = (state == FILL) && !issue_cnt[WORDS_LOG2] && !mem_stall;
  assign capture      = (state == FILL) && pipe_vld[MEM_LAT-1];
  assign fill_last    = capture && (&ret_cnt);

  // Next state and outputs
  always_comb begin
    state_nxt = state;
    data_out  = '0;
    done      = 1'b0;
    cache_hit = 1'b0;
    stall     = 1'b1;
    err       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        stall = 1'b0;
        done  = err_q;
        err   = err_q;
        if (rd ^ wr) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          done      = 1'b1;
          cache_hit = 1'b1;
          data_out  = req_wr ? req_data : rd_word;
          state_nxt = IDLE;
        end else if (valid[victim_sel][req_idx] && dirty[victim_sel][req_idx]) begin
          state_nxt = EVICT;
        end else begin
          state_nxt = FILL;
        end
      end
      EVICT: begin
        mem_wr    = 1'b1;
        mem_addr  = {tag_arr[victim][req_idx], req_idx, issue_word, 1'b0};
        mem_wdata = data_arr[victim][{req_idx, issue_word}];
        if (!mem_stall && (&issue_word)) state_nxt = FILL;
      end
      FILL: begin
        if (!issue_cnt[WORDS_LOG2]) begin
          mem_rd   = 1'b1;
          mem_addr = {req_tag, req_idx, issue_word, 1'b0};
        end
        if (fill_last) state_nxt = COMPLETE;
      end
      COMPLETE: begin
        done      = 1'b1;
        data_out  = req_wr ? req_data : rd_word;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_tag   <= '0;
      req_idx   <= '0;
      req_word  <= '0;
      req_data  <= '0;
      req_wr    <= 1'b0;
      err_q     <= 1'b0;
      victim    <= 1'b0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      state <= state_nxt;
      err_q <= (state == IDLE) && rd && wr;
      case (state)
        IDLE: begin
          if (rd ^ wr) begin
            req_tag  <= addr[ADDR_W-1 -: TAG_W];
            req_idx  <= addr[OFF_W +: INDEX_W];
            req_word <= addr[1 +: WORDS_LOG2];
            req_data <= data_in;
            req_wr   <= wr;
          end
        end
        COMPARE: begin
          victim    <= victim_sel;
          issue_cnt <= '0;
          ret_cnt   <= '0;
        end
        EVICT: begin
          if (!mem_stall) issue_cnt <= (&issue_word) ? '0 : issue_cnt + ISSUE_ONE;
        end
        FILL: begin
          if (issue_accept) issue_cnt <= issue_cnt + ISSUE_ONE;
          if (capture)      ret_cnt   <= ret_cnt + RET_ONE;
        end
        default: ;
      endcase
    end
  end

  // Each accepted read is tagged with its word index and matures after MEM_LAT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_word[i] <= '0;
    end else begin
      pipe_vld[0]  <= issue_accept;
      pipe_word[0] <= issue_word;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_word[i] <= pipe_word[i-1];
      end
    end
  end

  // Data and tag arrays (not reset)
  always_ff @(posedge clk) begin
    if (capture) data_arr[victim][{req_idx, pipe_word[MEM_LAT-1]}] <= mem_rdata;
    if (do_access && req_wr) data_arr[access_way][{req_idx, req_word}] <= req_data;
    if (fill_last) tag_arr[victim][req_idx] <= req_tag;
  end

  // Valid, dirty and LRU state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru      <= '0;
    end else begin
      if (fill_last) begin
        valid[victim][req_idx] <= 1'b1;
        dirty[victim][req_idx] <= 1'b0;
      end
      if (do_access) begin
        lru[req_idx] <= ~access_way;
        if (req_wr) dirty[access_way][req_idx] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_2way_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_2way_ctrl
// Purpose  : Directed self-checking bench for cache_2way_ctrl with a
//            word-addressed memory model (unwritten word at A holds A) and a
//            two-cycle read return.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_2way_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_out;
  logic        done;
  logic        cache_hit;
  logic        stall;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_stall = 1'b0;

  always #5 clk = ~clk;

  cache_2way_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .rd        (rd),
    .wr        (wr),
    .data_out  (data_out),
    .done      (done),
    .cache_hit (cache_hit),
    .stall     (stall),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall)
  );

  // Memory model
  logic [15:0]    mem [65536];
  logic [65535:0] written = '0;
  logic           p1_v;
  logic [15:0]    p1_a;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_v      <= 1'b0;
      p1_a      <= '0;
      mem_rdata <= '0;
    end else begin
      p1_v      <= mem_rd && !mem_stall;
      p1_a      <= mem_addr;
      mem_rdata <= p1_v ? (written[p1_a] ? mem[p1_a] : p1_a) : 16'h0;
      if (mem_wr && !mem_stall) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle log of the last request
  logic        t_rd    [64];
  logic        t_wr    [64];
  logic [15:0] t_addr  [64];
  logic [15:0] t_wdata [64];
  int          done_cyc;
  logic [15:0] d_out;
  logic        d_hit;
  logic        d_err;
  int          rd_cnt;
  int          wr_cnt;
  logic        both_seen;

  task automatic request(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input int s_from, input int s_to);
    @(negedge clk);
    rd = r; wr = w; addr = a; data_in = d; mem_stall = 1'b0;
    @(posedge clk);
    #1 rd = 1'b0; wr = 1'b0;
    done_cyc = -1; d_out = '0; d_hit = 1'b0; d_err = 1'b0;
    rd_cnt = 0; wr_cnt = 0; both_seen = 1'b0;
    for (int n = 0; n < 64; n++) begin
      t_rd[n] = 1'b0; t_wr[n] = 1'b0; t_addr[n] = '0; t_wdata[n] = '0;
    end
    for (int n = 1; n < 40; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      mem_stall = (n >= s_from) && (n <= s_to);
      @(negedge clk);
      t_rd[n] = mem_rd; t_wr[n] = mem_wr; t_addr[n] = mem_addr; t_wdata[n] = mem_wdata;
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
      if (mem_rd && mem_wr) both_seen = 1'b1;
      if (done) begin
        done_cyc = n; d_out = data_out; d_hit = cache_hit; d_err = err;
        break;
      end
    end
    mem_stall = 1'b0;
    check("rd_wr_exclusive", {31'b0, both_seen}, 32'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'b0, stall, done, cache_hit, err, mem_rd, mem_wr}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outputs", {26'b0, stall, done, cache_hit, err, mem_rd, mem_wr}, 32'd0);

    // 1: clean miss then hit
    request(1'b1, 1'b0, 16'h1234, 16'h0, 99, 0);
    check("t1_done_cyc", done_cyc, 8);
    check("t1_hit", {31'b0, d_hit}, 32'd0);
    check("t1_data", {16'b0, d_out}, 32'h1234);
    for (int k = 0; k < 4; k++) begin
      check("t1_fill_rd", {31'b0, t_rd[2+k]}, 32'd1);
      check("t1_fill_addr", {16'b0, t_addr[2+k]}, 32'h1230 + 2*k);
    end
    check("t1_rd_cnt", rd_cnt, 4);
    check("t1_wr_cnt", wr_cnt, 0);

    request(1'b1, 1'b0, 16'h1234, 16'h0, 99, 0);
    check("t1r_done_cyc", done_cyc, 1);
    check("t1r_hit", {31'b0, d_hit}, 32'd1);
    check("t1r_data", {16'b0, d_out}, 32'h1234);
    check("t1r_mem_activity", rd_cnt + wr_cnt, 0);

    // 2: write miss fills way1, then read hit
    request(1'b0, 1'b1, 16'h1634, 16'hBEEF, 99, 0);
    check("t2_done_cyc", done_cyc, 8);
    check("t2_hit", {31'b0, d_hit}, 32'd0);
    check("t2_data", {16'b0, d_out}, 32'hBEEF);
    request(1'b1, 1'b0, 16'h1634, 16'h0, 99, 0);
    check("t2r_done_cyc", done_cyc, 1);
    check("t2r_hit", {31'b0, d_hit}, 32'd1);
    check("t2r_data", {16'b0, d_out}, 32'hBEEF);

    // 3: touch way0, then dirty eviction of way1
    request(1'b1, 1'b0, 16'h1234, 16'h0, 99, 0);
    check("t3a_hit", {31'b0, d_hit}, 32'd1);
    request(1'b1, 1'b0, 16'h1A34, 16'h0, 99, 0);
    check("t3_done_cyc", done_cyc, 12);
    check("t3_hit", {31'b0, d_hit}, 32'd0);
    check("t3_data", {16'b0, d_out}, 32'h1A34);
    for (int k = 0; k < 4; k++) begin
      check("t3_evict_wr", {31'b0, t_wr[2+k]}, 32'd1);
      check("t3_evict_addr", {16'b0, t_addr[2+k]}, 32'h1630 + 2*k);
      check("t3_fill_addr", {16'b0, t_addr[6+k]}, 32'h1A30 + 2*k);
    end
    check("t3_evict_w0", {16'b0, t_wdata[2]}, 32'h1630);
    check("t3_evict_w1", {16'b0, t_wdata[3]}, 32'h1632);
    check("t3_evict_w2", {16'b0, t_wdata[4]}, 32'hBEEF);
    check("t3_evict_w3", {16'b0, t_wdata[5]}, 32'h1636);
    request(1'b1, 1'b0, 16'h1234, 16'h0, 99, 0);
    check("t3b_hit", {31'b0, d_hit}, 32'd1);
    check("t3b_data", {16'b0, d_out}, 32'h1234);

    // 4: simultaneous rd/wr -> error pulse
    request(1'b1, 1'b1, 16'h1234, 16'h5A5A, 99, 0);
    check("t4_done_cyc", done_cyc, 1);
    check("t4_err", {31'b0, d_err}, 32'd1);
    check("t4_mem", {30'b0, t_rd[1], t_wr[1]}, 32'd0);
    request(1'b1, 1'b0, 16'h1A34, 16'h0, 99, 0);
    check("t4n_hit", {31'b0, d_hit}, 32'd1);
    check("t4n_err", {31'b0, d_err}, 32'd0);
    check("t4n_data", {16'b0, d_out}, 32'h1A34);

    // Dirty both ways, then miss into EVICT and reset mid-eviction
    request(1'b0, 1'b1, 16'h1A34, 16'h5555, 99, 0);
    check("t6w1_hit", {31'b0, d_hit}, 32'd1);
    request(1'b0, 1'b1, 16'h1234, 16'h7777, 99, 0);
    check("t6w0_hit", {31'b0, d_hit}, 32'd1);
    @(negedge clk);
    rd = 1'b1; addr = 16'h1E34;
    @(posedge clk);
    #1 rd = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t6_evict_wr", {31'b0, mem_wr}, 32'd1);
    check("t6_evict_addr", {16'b0, mem_addr}, 32'h1A30);
    check("t6_evict_data", {16'b0, mem_wdata}, 32'h1A30);
    check("t6_stall_pre", {31'b0, stall}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_ctrl", {26'b0, stall, done, cache_hit, err, mem_rd, mem_wr}, 32'd0);
    check("t6_rst_bus", {mem_addr, mem_wdata}, 32'd0);
    check("t6_rst_dout", {16'b0, data_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 5: after reset, miss with mem_stall over FILL issue cycles 3..5
    request(1'b1, 1'b0, 16'h1234, 16'h0, 3, 5);
    check("t5_done_cyc", done_cyc, 11);
    check("t5_hit", {31'b0, d_hit}, 32'd0);
    check("t5_data", {16'b0, d_out}, 32'h1234);
    for (int k = 3; k <= 6; k++) begin
      check("t5_held_addr", {16'b0, t_addr[k]}, 32'h1232);
      check("t5_held_rd", {31'b0, t_rd[k]}, 32'd1);
    end
    check("t5_last_addr", {16'b0, t_addr[8]}, 32'h1236);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
